// File: rtl/mem_interface_unit_pkg.sv
// Shared definitions for the memory interface unit: access-size codes,
// FSM state encodings, read/write polarity and the alignment helper.
package mem_interface_unit_pkg;

   typedef enum logic [1:0] {
      DT_BYTE = 2'b00,
      DT_HALF = 2'b01,
      DT_WORD = 2'b10,
      DT_RSVD = 2'b11
   } dtype_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Reserved size code behaves like a word.
   function automatic logic misaligned(input logic [1:0] dt,
                                       input logic [1:0] a);
      logic r;
      r = 1'b0;
      case (dt)
         DT_BYTE: r = 1'b0;
         DT_HALF: r = a[0];
         default: r = |a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_interface_unit_ram_bytes.sv
// Byte RAM, 2**ADDR_W x 8: four async read ports at addr_i+0..3 (wrapping)
// and four synchronous write lanes at the same addresses.
// Ports: clk_i, addr_i (base byte address), we_i (per-lane write enable),
//        wdata_i (per-lane write byte), rdata_o (per-lane read byte).
module ram_bytes #(
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [3:0]        we_i,
   input  logic [3:0][7:0]   wdata_i,
   output logic [3:0][7:0]   rdata_o
);

   logic [7:0]              mem_q [2**ADDR_W];
   logic [3:0][ADDR_W-1:0]  lane_addr;

   // Lane k targets addr+k modulo the RAM size.
   always_comb begin
      lane_addr = '0;
      rdata_o   = '0;
      for (int k = 0; k < 4; k++) begin
         lane_addr[k] = addr_i + ADDR_W'(k);
         rdata_o[k]   = mem_q[lane_addr[k]];
      end
   end

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 4; k++) begin
         if (we_i[k]) mem_q[lane_addr[k]] <= wdata_i[k];
      end
   end

endmodule

// File: rtl/mem_interface_unit.sv
// Memory interface stage: MAR, MDR, big-endian byte RAM, MOV/MOC handshake.
// Ports: CLK, RESET (async high), MAR_LD/MDR_LD/ALU_IN (register loads),
//        RW/MOV/DTYPE (request), MOC (complete), MAR_OUT, MDR_OUT, ALIGN_ERR.
// Option: define MEM_ALIGN_CHECK_EN to suppress misaligned accesses and flag
//         them on ALIGN_ERR; otherwise ALIGN_ERR is 0 and accesses wrap.
module mem_interface_unit
   import mem_interface_unit_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MAR_LD,
   input  logic        MDR_LD,
   input  logic [31:0] ALU_IN,
   input  logic        RW,
   input  logic        MOV,
   input  logic [1:0]  DTYPE,
   output logic        MOC,
   output logic [31:0] MAR_OUT,
   output logic [31:0] MDR_OUT,
   output logic        ALIGN_ERR
);

   localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                rw_q;
   logic [1:0]          dtype_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                bad_q;
   logic [31:0]         mar_q;
   logic [31:0]         mdr_q;
   logic                moc_q;
   logic                align_q;

   logic                bad_d;
   logic                complete;
   logic [3:0]          we;
   logic [3:0][7:0]     wdata;
   logic [3:0][7:0]     rdata;
   logic [31:0]         rd_word;
   logic                unused_mar;

`ifdef MEM_ALIGN_CHECK_EN
   assign bad_d = misaligned(DTYPE, mar_q[1:0]);
`else
   assign bad_d = 1'b0;
`endif

   assign unused_mar = ^mar_q[31:ADDR_W];
   assign complete   = (state_q == ST_BUSY) && (cnt_q == '0);

   // Big-endian steering: lane 0 is the lowest address and the MSB.
   always_comb begin
      we      = '0;
      wdata   = '0;
      rd_word = '0;
      if (complete && (rw_q == RW_WRITE) && !bad_q) begin
         case (dtype_q)
            DT_BYTE: begin
               we       = 4'b0001;
               wdata[0] = mdr_q[7:0];
            end
            DT_HALF: begin
               we       = 4'b0011;
               wdata[0] = mdr_q[15:8];
               wdata[1] = mdr_q[7:0];
            end
            default: begin
               we       = 4'b1111;
               wdata[0] = mdr_q[31:24];
               wdata[1] = mdr_q[23:16];
               wdata[2] = mdr_q[15:8];
               wdata[3] = mdr_q[7:0];
            end
         endcase
      end
      case (dtype_q)
         DT_BYTE: rd_word = {24'h0, rdata[0]};
         DT_HALF: rd_word = {16'h0, rdata[0], rdata[1]};
         default: rd_word = {rdata[0], rdata[1], rdata[2], rdata[3]};
      endcase
   end

   ram_bytes #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (CLK),
      .addr_i  (addr_q),
      .we_i    (we),
      .wdata_i (wdata),
      .rdata_o (rdata)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rw_q    <= RW_READ;
         dtype_q <= '0;
         addr_q  <= '0;
         bad_q   <= 1'b0;
         mar_q   <= '0;
         mdr_q   <= '0;
         moc_q   <= 1'b0;
         align_q <= 1'b0;
      end else begin
         // Register loads are locked out only while the access is in flight.
         if ((state_q != ST_BUSY) && MAR_LD) mar_q <= ALU_IN;
         if ((state_q != ST_BUSY) && MDR_LD) mdr_q <= ALU_IN;
         case (state_q)
            ST_IDLE: begin
               if (MOV) begin
                  rw_q    <= RW;
                  dtype_q <= DTYPE;
                  addr_q  <= mar_q[ADDR_W-1:0];
                  bad_q   <= bad_d;
                  cnt_q   <= CNT_INIT;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  if ((rw_q == RW_READ) && !bad_q) mdr_q <= rd_word;
                  moc_q   <= 1'b1;
                  align_q <= bad_q;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!MOV) begin
                  moc_q   <= 1'b0;
                  align_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign MOC       = moc_q;
   assign MAR_OUT   = mar_q;
   assign MDR_OUT   = mdr_q;
   assign ALIGN_ERR = align_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed bench for mem_interface_unit with a byte-array reference model
// and a queue of expected read data popped at each MOC.
module tb_mem_interface_unit;

   localparam int WAIT = 2;

   logic        CLK;
   logic        RESET;
   logic        MAR_LD;
   logic        MDR_LD;
   logic [31:0] ALU_IN;
   logic        RW;
   logic        MOV;
   logic [1:0]  DTYPE;
   logic        MOC;
   logic [31:0] MAR_OUT;
   logic [31:0] MDR_OUT;
   logic        ALIGN_ERR;

   mem_interface_unit #(
      .ADDR_W      (8),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .MAR_LD    (MAR_LD),
      .MDR_LD    (MDR_LD),
      .ALU_IN    (ALU_IN),
      .RW        (RW),
      .MOV       (MOV),
      .DTYPE     (DTYPE),
      .MOC       (MOC),
      .MAR_OUT   (MAR_OUT),
      .MDR_OUT   (MDR_OUT),
      .ALIGN_ERR (ALIGN_ERR)
   );

   always #5 CLK = ~CLK;

   logic [7:0]  mdl [256];
   logic [31:0] mar_m;
   logic [31:0] mdr_m;
   logic [31:0] exp_q [$];
   int          n_chk;
   int          n_fail;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic mis(input logic [1:0] dt, input logic [7:0] a);
`ifdef MEM_ALIGN_CHECK_EN
      if (dt == 2'd0) return 1'b0;
      if (dt == 2'd1) return a[0];
      return |a[1:0];
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] mread(input logic [7:0] a,
                                         input logic [1:0] dt);
      if (dt == 2'd0) return {24'h0, mdl[a]};
      if (dt == 2'd1) return {16'h0, mdl[a], mdl[8'(a + 1)]};
      return {mdl[a], mdl[8'(a + 1)], mdl[8'(a + 2)], mdl[8'(a + 3)]};
   endfunction

   task automatic mwrite(input logic [7:0] a, input logic [1:0] dt,
                         input logic [31:0] d);
      if (dt == 2'd0) begin
         mdl[a] = d[7:0];
      end else if (dt == 2'd1) begin
         mdl[a]            = d[15:8];
         mdl[8'(a + 1)]    = d[7:0];
      end else begin
         mdl[a]            = d[31:24];
         mdl[8'(a + 1)]    = d[23:16];
         mdl[8'(a + 2)]    = d[15:8];
         mdl[8'(a + 3)]    = d[7:0];
      end
   endtask

   task automatic ld(input logic is_mar, input logic [31:0] v);
      @(negedge CLK);
      MAR_LD = is_mar;
      MDR_LD = !is_mar;
      ALU_IN = v;
      @(negedge CLK);
      MAR_LD = 1'b0;
      MDR_LD = 1'b0;
      if (is_mar) begin
         mar_m = v;
         chk("mar_ld", MAR_OUT, mar_m);
      end else begin
         mdr_m = v;
         chk("mdr_ld", MDR_OUT, mdr_m);
      end
   endtask

   task automatic op(input logic rw, input logic [1:0] dt, input int hold,
                     input logic ld_done, input logic [31:0] ld_val);
      logic [7:0]  a;
      logic        bad;
      logic [31:0] e;
      int          n;
      a   = mar_m[7:0];
      bad = mis(dt, a);
      @(negedge CLK);
      MOV   = 1'b1;
      RW    = rw;
      DTYPE = dt;
      if (rw) begin
         e = bad ? mdr_m : mread(a, dt);
         exp_q.push_back(e);
      end else if (!bad) begin
         mwrite(a, dt, mdr_m);
      end
      @(posedge CLK);
      #1;
      // Disturb everything that must be ignored once the request is taken.
      RW     = ~rw;
      DTYPE  = ~dt;
      MAR_LD = 1'b1;
      MDR_LD = 1'b1;
      ALU_IN = 32'hBAD0_BAD0;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (MOC !== 1'b1 && n < 20);
      MAR_LD = 1'b0;
      MDR_LD = 1'b0;
      chk("latency", 32'(n), 32'(WAIT + 2));
      chk("align_done", {31'h0, ALIGN_ERR}, {31'h0, bad});
      chk("mar_busy_hold", MAR_OUT, mar_m);
      if (rw) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            mdr_m = exp_q.pop_front();
         end
      end
      chk("mdr_done", MDR_OUT, mdr_m);
      if (ld_done) begin
         MDR_LD = 1'b1;
         ALU_IN = ld_val;
         @(negedge CLK);
         MDR_LD = 1'b0;
         mdr_m  = ld_val;
         chk("mdr_ld_in_done", MDR_OUT, mdr_m);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge CLK);
         chk("moc_hold", {31'h0, MOC}, 32'd1);
      end
      MOV = 1'b0;
      @(negedge CLK);
      chk("moc_drop", {31'h0, MOC}, 32'd0);
      chk("align_drop", {31'h0, ALIGN_ERR}, 32'd0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      CLK    = 1'b0;
      RESET  = 1'b1;
      MAR_LD = 1'b0;
      MDR_LD = 1'b0;
      ALU_IN = '0;
      RW     = 1'b1;
      MOV    = 1'b0;
      DTYPE  = 2'd0;
      mar_m  = '0;
      mdr_m  = '0;
      for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
      repeat (2) @(negedge CLK);
      chk("rst_moc", {31'h0, MOC}, 32'd0);
      chk("rst_mar", MAR_OUT, 32'd0);
      chk("rst_mdr", MDR_OUT, 32'd0);
      chk("rst_align", {31'h0, ALIGN_ERR}, 32'd0);
      RESET = 1'b0;

      // Word write then read back, plus per-byte big-endian layout.
      ld(1'b1, 32'h0000_0010);
      ld(1'b0, 32'hDEAD_BEEF);
      op(1'b0, 2'd2, 0, 1'b0, '0);
      ld(1'b0, 32'h0);
      op(1'b1, 2'd2, 0, 1'b0, '0);
      for (int k = 0; k < 4; k++) begin
         ld(1'b1, 32'h10 + 32'(k));
         op(1'b1, 2'd0, 0, 1'b0, '0);
      end

      // Byte and halfword reads are zero-extended.
      ld(1'b1, 32'h0000_0011);
      op(1'b1, 2'd0, 0, 1'b0, '0);
      ld(1'b1, 32'h0000_0012);
      op(1'b1, 2'd1, 0, 1'b0, '0);

      // Long MOV hold, MDR_LD during DONE, reserved size as word.
      ld(1'b1, 32'hFFFF_FF10);
      op(1'b1, 2'd2, 5, 1'b1, 32'h1234_5678);
      op(1'b1, 2'd3, 0, 1'b0, '0);

      // Halfword and byte writes building a word at 0x20.
      ld(1'b1, 32'h0000_0020);
      ld(1'b0, 32'h5555_A1B2);
      op(1'b0, 2'd1, 0, 1'b0, '0);
      ld(1'b1, 32'h0000_0022);
      ld(1'b0, 32'h7777_77C3);
      op(1'b0, 2'd0, 0, 1'b0, '0);
      ld(1'b1, 32'h0000_0023);
      ld(1'b0, 32'h0000_00D4);
      op(1'b0, 2'd0, 0, 1'b0, '0);
      ld(1'b1, 32'h0000_0024);
      ld(1'b0, 32'h0102_0304);
      op(1'b0, 2'd2, 0, 1'b0, '0);
      ld(1'b1, 32'h0000_0020);
      op(1'b1, 2'd2, 0, 1'b0, '0);

      // Unaligned word read and halfword write.
      ld(1'b1, 32'h0000_0021);
      op(1'b1, 2'd2, 0, 1'b0, '0);
      ld(1'b1, 32'h0000_0025);
      ld(1'b0, 32'h0000_EEFF);
      op(1'b0, 2'd1, 0, 1'b0, '0);
      ld(1'b1, 32'h0000_0024);
      op(1'b1, 2'd2, 0, 1'b0, '0);

      // Wrap-around at the top of the RAM.
      for (int k = 0; k < 4; k++) begin
         ld(1'b1, 32'(8'hFF + 8'(k)));
         ld(1'b0, 32'h90 + 32'(k));
         op(1'b0, 2'd0, 0, 1'b0, '0);
      end
      ld(1'b1, 32'h0000_00FF);
      ld(1'b0, 32'h1122_3344);
      op(1'b0, 2'd2, 0, 1'b0, '0);
      for (int k = 0; k < 4; k++) begin
         ld(1'b1, 32'(8'hFF + 8'(k)));
         op(1'b1, 2'd0, 0, 1'b0, '0);
      end
      ld(1'b1, 32'h0000_00FF);
      op(1'b1, 2'd2, 0, 1'b0, '0);

      // Reset during BUSY aborts the write.
      ld(1'b1, 32'h0000_0040);
      ld(1'b0, 32'hCAFE_F00D);
      op(1'b0, 2'd2, 0, 1'b0, '0);
      ld(1'b0, 32'h5566_7788);
      @(negedge CLK);
      MOV   = 1'b1;
      RW    = 1'b0;
      DTYPE = 2'd2;
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("abort_moc", {31'h0, MOC}, 32'd0);
      chk("abort_mdr", MDR_OUT, 32'd0);
      chk("abort_mar", MAR_OUT, 32'd0);
      chk("abort_align", {31'h0, ALIGN_ERR}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      MOV   = 1'b0;
      mar_m = '0;
      mdr_m = '0;
      ld(1'b1, 32'h0000_0040);
      op(1'b1, 2'd2, 0, 1'b0, '0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
